// File: rtl/enemy_pkg.sv
// enemy_pkg: shared types and defaults for the enemy path engine
package enemy_pkg;
  localparam int DEF_RADIUS = 8;
  typedef enum logic [1:0] {STATIC, LIN_X, LIN_Y, RECT} enemy_mode_t;
  typedef enum logic [1:0] {PX, PY, NX, NY} enemy_seg_t;
  typedef struct packed {
    logic        en;
    enemy_mode_t mode;
    logic        dir;
  } enemy_cfg_t;
endpackage

// File: rtl/enemy_channel.sv
// enemy_channel: one enemy's config latch, path stepping and hit/draw tests.
// Mode 3 walks the four-leg rectangle only when ENEMY_RECT_MODE_EN is defined.
module enemy_channel import enemy_pkg::*; #(
  parameter int COORD_W = 10,
  parameter int SPEED_W = 4,
  parameter int RADIUS  = DEF_RADIUS
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start_enemies,
  input  logic               pause,
  input  logic               cfg_en,
  input  logic [1:0]         cfg_mode,
  input  logic               cfg_dir,
  input  logic [SPEED_W-1:0] cfg_speed,
  input  logic [COORD_W-1:0] cfg_x,
  input  logic [COORD_W-1:0] cfg_y,
  input  logic [COORD_W-1:0] cfg_rx,
  input  logic [COORD_W-1:0] cfg_ry,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] player_s,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               hit,
  output logic               draw
);
  localparam int SQ_W = 2 * (COORD_W + 1);
  localparam logic signed [SQ_W-1:0] R2 = SQ_W'(RADIUS * RADIUS);
  enemy_cfg_t         cfg_q, cfg_d;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [COORD_W-1:0] rx_q, rx_d, ry_q, ry_d, pos_x_q, pos_x_d, pos_y_q, pos_y_d, cnt_q, cnt_d;
  logic [1:0]         seg_q, seg_d;
  logic               run_q, run_d;
  enemy_seg_t         heading;
  logic [COORD_W-1:0] len, rem, step;
  logic               moving, last_seg, leg_y;
  logic signed [SQ_W-1:0] pdx, pdy, ddx, ddy, reach;
  always_comb begin
    heading  = (cfg_q.dir ^ seg_q[0]) ? PX : NX;
    leg_y    = 1'b0;
    last_seg = seg_q[0];
    moving   = run_q & ~pause;
    case (cfg_q.mode)
      LIN_X: ;
      LIN_Y: heading = (cfg_q.dir ^ seg_q[0]) ? NY : PY;
`ifdef ENEMY_RECT_MODE_EN
      RECT: begin
        heading  = enemy_seg_t'(seg_q ^ {1'b0, ~cfg_q.dir});
        leg_y    = seg_q[0] ^ ~cfg_q.dir;
        last_seg = &seg_q;
      end
`endif
      default: moving = 1'b0;
    endcase
    len  = leg_y ? ry_q : rx_q;
    rem  = len - cnt_q;
    step = (COORD_W'(speed_q) < rem) ? COORD_W'(speed_q) : rem;
  end
  always_comb begin
    cfg_d   = cfg_q;
    speed_d = speed_q;
    rx_d    = rx_q;
    ry_d    = ry_q;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    cnt_d   = cnt_q;
    seg_d   = seg_q;
    run_d   = run_q;
    if (start_enemies) begin
      cfg_d   = '{cfg_en, enemy_mode_t'(cfg_mode), cfg_dir};
      speed_d = cfg_speed;
      rx_d    = cfg_rx;
      ry_d    = cfg_ry;
      pos_x_d = cfg_x;
      pos_y_d = cfg_y;
      cnt_d   = '0;
      seg_d   = '0;
      run_d   = 1'b1;
    end else if (moving) begin
      pos_x_d = heading == PX ? pos_x_q + step : heading == NX ? pos_x_q - step : pos_x_q;
      pos_y_d = heading == PY ? pos_y_q + step : heading == NY ? pos_y_q - step : pos_y_q;
      cnt_d   = step == rem ? '0 : cnt_q + step;
      seg_d   = step != rem ? seg_q : last_seg ? 2'd0 : seg_q + 2'd1;
    end
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      cfg_q   <= '0;
      speed_q <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      pos_x_q <= '0;
      pos_y_q <= '0;
      cnt_q   <= '0;
      seg_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      speed_q <= speed_d;
      rx_q    <= rx_d;
      ry_q    <= ry_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      run_q   <= run_d;
    end
  end
  // zero-extended operands subtracted at full width give exact signed offsets
  always_comb begin
    pdx   = SQ_W'(player_x) - SQ_W'(pos_x_q);
    pdy   = SQ_W'(player_y) - SQ_W'(pos_y_q);
    ddx   = SQ_W'(draw_x) - SQ_W'(pos_x_q);
    ddy   = SQ_W'(draw_y) - SQ_W'(pos_y_q);
    reach = SQ_W'(RADIUS) + SQ_W'(player_s >> 1);
    hit   = cfg_q.en & run_q & (pdx * pdx + pdy * pdy < reach * reach);
    draw  = cfg_q.en & (ddx * ddx + ddy * ddy < R2);
  end
endmodule

// File: rtl/enemy_path_engine.sv
// enemy_path_engine: N enemy channels with registered player collision and per-pixel draw select.
// Define ENEMY_RECT_MODE_EN to build the four-leg rectangle path for mode 3.
module enemy_path_engine import enemy_pkg::*; #(
  parameter  int N_ENEMIES = 8,
  parameter  int COORD_W   = 10,
  parameter  int SPEED_W   = 4,
  parameter  int RADIUS    = DEF_RADIUS,
  localparam int IDX_W     = N_ENEMIES > 1 ? $clog2(N_ENEMIES) : 1
) (
  input  logic                         frame_clk,
  input  logic                         Reset,
  input  logic                         start_enemies,
  input  logic                         pause,
  input  logic [N_ENEMIES-1:0]         cfg_en,
  input  logic [N_ENEMIES*2-1:0]       cfg_mode,
  input  logic [N_ENEMIES-1:0]         cfg_dir,
  input  logic [N_ENEMIES*SPEED_W-1:0] cfg_speed,
  input  logic [N_ENEMIES*COORD_W-1:0] cfg_x,
  input  logic [N_ENEMIES*COORD_W-1:0] cfg_y,
  input  logic [N_ENEMIES*COORD_W-1:0] cfg_rx,
  input  logic [N_ENEMIES*COORD_W-1:0] cfg_ry,
  input  logic [COORD_W-1:0]           PlayerX,
  input  logic [COORD_W-1:0]           PlayerY,
  input  logic [COORD_W-1:0]           PlayerS,
  input  logic [COORD_W-1:0]           DrawX,
  input  logic [COORD_W-1:0]           DrawY,
  output logic                         collision,
  output logic [IDX_W-1:0]             collision_idx,
  output logic                         print_enemy,
  output logic [IDX_W-1:0]             print_idx
);
  logic [N_ENEMIES-1:0] hit, draw;
  logic [IDX_W-1:0]     hit_idx, draw_idx, collision_idx_d, collision_idx_q;
  logic                 collision_d, collision_q;
  for (genvar i = 0; i < N_ENEMIES; i++) begin : g_ch
    enemy_channel #(.COORD_W(COORD_W), .SPEED_W(SPEED_W), .RADIUS(RADIUS)) u_ch (
      .frame_clk     (frame_clk),
      .Reset         (Reset),
      .start_enemies (start_enemies),
      .pause         (pause),
      .cfg_en        (cfg_en[i]),
      .cfg_mode      (cfg_mode[2*i +: 2]),
      .cfg_dir       (cfg_dir[i]),
      .cfg_speed     (cfg_speed[SPEED_W*i +: SPEED_W]),
      .cfg_x         (cfg_x[COORD_W*i +: COORD_W]),
      .cfg_y         (cfg_y[COORD_W*i +: COORD_W]),
      .cfg_rx        (cfg_rx[COORD_W*i +: COORD_W]),
      .cfg_ry        (cfg_ry[COORD_W*i +: COORD_W]),
      .player_x      (PlayerX),
      .player_y      (PlayerY),
      .player_s      (PlayerS),
      .draw_x        (DrawX),
      .draw_y        (DrawY),
      .hit           (hit[i]),
      .draw          (draw[i])
    );
  end
  // scanning downward leaves the lowest active index in place
  always_comb begin
    hit_idx  = '0;
    draw_idx = '0;
    for (int i = N_ENEMIES - 1; i >= 0; i--) begin
      hit_idx  = hit[i]  ? IDX_W'(i) : hit_idx;
      draw_idx = draw[i] ? IDX_W'(i) : draw_idx;
    end
    collision_d     = ~start_enemies & (|hit);
    collision_idx_d = start_enemies ? '0 : hit_idx;
  end
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      collision_q     <= 1'b0;
      collision_idx_q <= '0;
    end else begin
      collision_q     <= collision_d;
      collision_idx_q <= collision_idx_d;
    end
  end
  assign collision     = collision_q;
  assign collision_idx = collision_idx_q;
  assign print_enemy   = |draw;
  assign print_idx     = draw_idx;
endmodule
